twiddle_feeder: RTL

//  Initiator/sequencer for the FFT32 3-multiplier twiddle multiplier (twiddle_mult).

---
 rtl/fft32_pkg.sv | 73 +++++++
 rtl/twiddle_rom.sv | 26 ++
 rtl/twiddle_feeder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fft32_pkg.sv
// Shared definitions for the FFT32 twiddle path.
//   - Transform size, operand width and twiddle ROM geometry.
//   - Feeder FSM state type.
//   - Twiddle table: c = round(127*cos(2*pi*k/32)), s = round(-127*sin(2*pi*k/32)),
//     stored as c (8b) plus exact 9-bit c+s and c-s for the 3-multiplier rotator.
//   - Twiddle exponent derivation from FFT stage and butterfly index.
package fft32_pkg;

    localparam int unsigned N         = 32;
    localparam int unsigned FFT_DW    = 8;
    localparam int unsigned ROM_DEPTH = N / 2;
    localparam int unsigned ROM_AW    = $clog2(ROM_DEPTH);
    localparam int unsigned STAGE_W   = 3;
    localparam int unsigned MAX_STAGE = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } state_e;

    typedef struct packed {
        logic signed [7:0] c;
        logic signed [8:0] c_plus_s;
        logic signed [8:0] c_minus_s;
    } twiddle_t;

    function automatic twiddle_t twiddle_entry(input logic [ROM_AW-1:0] k);
        logic signed [7:0] c;
        logic signed [7:0] s;
        twiddle_t          e;
        case (k)
            4'd0:    begin c =  8'sd127; s =  8'sd0;   end
            4'd1:    begin c =  8'sd125; s = -8'sd25;  end
            4'd2:    begin c =  8'sd117; s = -8'sd49;  end
            4'd3:    begin c =  8'sd106; s = -8'sd71;  end
            4'd4:    begin c =  8'sd90;  s = -8'sd90;  end
            4'd5:    begin c =  8'sd71;  s = -8'sd106; end
            4'd6:    begin c =  8'sd49;  s = -8'sd117; end
            4'd7:    begin c =  8'sd25;  s = -8'sd125; end
            4'd8:    begin c =  8'sd0;   s = -8'sd127; end
            4'd9:    begin c = -8'sd25;  s = -8'sd125; end
            4'd10:   begin c = -8'sd49;  s = -8'sd117; end
            4'd11:   begin c = -8'sd71;  s = -8'sd106; end
            4'd12:   begin c = -8'sd90;  s = -8'sd90;  end
            4'd13:   begin c = -8'sd106; s = -8'sd71;  end
            4'd14:   begin c = -8'sd117; s = -8'sd49;  end
            default: begin c = -8'sd125; s = -8'sd25;  end
        endcase
        e.c = c;
        // Sign-extend to 9 bits first so the sum/difference never wraps.
        e.c_plus_s  = {c[7], c} + {s[7], s};
        e.c_minus_s = {c[7], c} - {s[7], s};
        return e;
    endfunction

    // k = (j mod 2^st) << (4 - st), st = min(stage, 4)
    function automatic logic [ROM_AW-1:0] twiddle_exp(input logic [STAGE_W-1:0] stage,
                                                      input logic [ROM_AW-1:0]  j);
        logic [ROM_AW-1:0] k;
        case (stage)
            3'd0:    k = '0;
            3'd1:    k = {j[0],   3'b000};
            3'd2:    k = {j[1:0], 2'b00};
            3'd3:    k = {j[2:0], 1'b0};
            default: k = j;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Combinational twiddle ROM for the 32-point FFT.
// Ports:
//   addr_i       in  4  twiddle exponent k (0..15)
//   c_o          out 8  round(127*cos)
//   c_plus_s_o   out 9  c + s, exact
//   c_minus_s_o  out 9  c - s, exact
module twiddle_rom
    import fft32_pkg::*;
(
    input  logic [ROM_AW-1:0] addr_i,
    output logic [7:0]        c_o,
    output logic [8:0]        c_plus_s_o,
    output logic [8:0]        c_minus_s_o
);

    twiddle_t entry;

    always_comb begin
        entry = twiddle_entry(addr_i);
    end

    assign c_o         = entry.c;
    assign c_plus_s_o  = entry.c_plus_s;
    assign c_minus_s_o = entry.c_minus_s;

endmodule

// File: rtl/twiddle_feeder.sv
// Sequencer feeding the 3-multiplier twiddle rotator.
// Accepts one complex operand with its stage/butterfly position, looks up the
// twiddle, pulses the multiplier start, waits (bounded) for the multiplier
// result and presents it downstream with a valid/ready handshake.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   i_valid / o_ready             upstream handshake (o_ready only in IDLE)
//   i_x, i_y, i_stage, i_j        operand and butterfly position
//   o_mx, o_my                    operand to multiplier
//   o_mc, o_mc_plus_s, o_mc_minus_s  twiddle to multiplier
//   o_mstart                      1-cycle multiplier start
//   i_mdata_valid, i_mre, i_mim   multiplier result
//   o_valid / i_ready, o_re, o_im downstream handshake and result
//   o_error                       sticky timeout flag
module twiddle_feeder
    import fft32_pkg::*;
#(
    parameter int unsigned DW      = FFT_DW,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [DW-1:0]      i_x,
    input  logic [DW-1:0]      i_y,
    input  logic [STAGE_W-1:0] i_stage,
    input  logic [ROM_AW-1:0]  i_j,
    output logic [DW-1:0]      o_mx,
    output logic [DW-1:0]      o_my,
    output logic [7:0]         o_mc,
    output logic [8:0]         o_mc_plus_s,
    output logic [8:0]         o_mc_minus_s,
    output logic               o_mstart,
    input  logic               i_mdata_valid,
    input  logic [DW-1:0]      i_mre,
    input  logic [DW-1:0]      i_mim,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DW-1:0]      o_re,
    output logic [DW-1:0]      o_im,
    output logic               o_error
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [DW-1:0]     x_q, x_d;
    logic [DW-1:0]     y_q, y_d;
    logic [ROM_AW-1:0] k_q, k_d;
    logic [DW-1:0]     mx_q, mx_d;
    logic [DW-1:0]     my_q, my_d;
    logic [7:0]        mc_q, mc_d;
    logic [8:0]        mcps_q, mcps_d;
    logic [8:0]        mcms_q, mcms_d;
    logic [DW-1:0]     re_q, re_d;
    logic [DW-1:0]     im_q, im_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [7:0]        rom_c;
    logic [8:0]        rom_cps;
    logic [8:0]        rom_cms;

    twiddle_rom u_rom (
        .addr_i      (k_q),
        .c_o         (rom_c),
        .c_plus_s_o  (rom_cps),
        .c_minus_s_o (rom_cms)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        k_d     = k_q;
        mx_d    = mx_q;
        my_d    = my_q;
        mc_d    = mc_q;
        mcps_d  = mcps_q;
        mcms_d  = mcms_q;
        re_d    = re_q;
        im_d    = im_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    x_d     = i_x;
                    y_d     = i_y;
                    k_d     = twiddle_exp(i_stage, i_j);
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                mx_d    = x_q;
                my_d    = y_q;
                mc_d    = rom_c;
                mcps_d  = rom_cps;
                mcms_d  = rom_cms;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                // cnt_q counts cycles since ISSUE, so the first WAIT cycle sees 1.
                cnt_d   = CW'(1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving in the last allowed cycle wins over the timeout.
                if (i_mdata_valid) begin
                    re_d    = i_mre;
                    im_d    = i_mim;
                    state_d = ST_HOLD;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_HOLD: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            mx_q    <= '0;
            my_q    <= '0;
            mc_q    <= '0;
            mcps_q  <= '0;
            mcms_q  <= '0;
            re_q    <= '0;
            im_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            k_q     <= k_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
            mc_q    <= mc_d;
            mcps_q  <= mcps_d;
            mcms_q  <= mcms_d;
            re_q    <= re_d;
            im_q    <= im_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Gated by reset so o_ready reads 0 while reset is held.
    assign o_ready      = (state_q == ST_IDLE) && !reset;
    assign o_mstart     = (state_q == ST_ISSUE);
    assign o_valid      = (state_q == ST_HOLD);
    assign o_mx         = mx_q;
    assign o_my         = my_q;
    assign o_mc         = mc_q;
    assign o_mc_plus_s  = mcps_q;
    assign o_mc_minus_s = mcms_q;
    assign o_re         = re_q;
    assign o_im         = im_q;
    assign o_error      = err_q;

endmodule
